digit_serial_sub32: RTL and testbench
=====================================

Name: digit_serial_sub32

Overview:
- Multi-cycle 32-bit subtractor computing diff = a - b with borrow-out and signed overflow.
- Processes one DIGIT_W-bit slice per clock, LSB slice first, with a registered borrow chain.
- Counterpart to the team's combinational 32-bit adders: the subtract direction for area-constrained datapaths.
- Start/busy/done handshake; sits behind the ALU controller.

Parameters:
- WIDTH, 32, operand and result width.
- DIGIT_W, 8, bits processed per cycle. WIDTH must be an integer multiple of DIGIT_W. N = WIDTH/DIGIT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b unsigned.
- ovf  output  1  signed overflow = (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB]).

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; slice counter=0; borrow register=0; operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> capture a and b, clear the borrow register, set counter=0, go to RUN, busy=1.
- RUN: on each edge:
  - slice[k] of diff = a_slice - b_slice - borrow;
  - borrow register <= slice borrow-out;
  - counter increments.
- RUN, after slice N-1 (the Nth RUN edge): go to DONE; busy=0, done=1; bout = final borrow; ovf computed from captured operand MSBs and diff MSB.
- DONE: lasts exactly one cycle, then returns to IDLE (done=0).
- DONE + start=1: accepted like IDLE (captures operands, enters RUN). Back-to-back issue is allowed; done still deasserts on that edge.
- Latency: start sampled at edge E0; done=1 in the cycle following edge E0+N. For defaults, done is high after 4 RUN edges. Throughput is one result per N+1 cycles.
- start while busy=1: ignored. Operands do not change; the counter is not disturbed.
- a and b may change freely after the accepting edge.
- diff, bout and ovf hold their last completed values until the next DONE.
- During RUN, diff slices are written progressively. Consumers must use diff only when done=1 or after it.
- Borrow ripple: the borrow must propagate across slice boundaries through the register (e.g. 0 - 1 produces all-ones across every slice).
- Reset asserted mid-RUN: immediate abort. All outputs return to reset values; no done pulse. A new start is needed after rst_n releases.
- No X propagation: all registers are reset.

Test Plan:
- After reset, no start -> busy=0, done=0, diff=0x00000000, bout=0, ovf=0 for 10 cycles.
- a=0x00000005, b=0x00000003, start for 1 cycle -> busy high 4 cycles, then done pulse; diff=0x00000002, bout=0, ovf=0.
- a=0xA0A0E1FF, b=0xA0BFFFE0 -> diff=0xFFE0E21F, bout=1, ovf=0. Then a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, bout=1, ovf=0 (full borrow ripple).
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, bout=0, ovf=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, bout=1, ovf=1.
- Handshake: start pulsed again with a=0x11111111 during RUN -> ignored, original result returned. Start held high in the DONE cycle with a=0x00000010, b=0x00000001 -> second done exactly 5 cycles later with diff=0x0000000F.
- Reset mid-op: rst_n=0 asynchronously after 2 RUN edges -> outputs immediately 0, no done. Release rst_n, issue a=0x00000009, b=0x00000009 -> diff=0x00000000, bout=0, ovf=0.

Source files
------------

// File: rtl/digit_serial_sub32.sv
// Digit-serial subtractor: diff = a - b, one DIGIT_W slice per clock, LSB first,
// borrow carried between slices in a register. Start/busy/done handshake.
module digit_serial_sub32 #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_borrow;
    logic               r_busy;
    logic               r_done;
    logic               r_bout;
    logic               r_ovf;

    logic [DIGIT_W:0]   w_sub;
    logic [DIGIT_W-1:0] w_slice;
    logic               w_slice_bo;
    logic               w_accept;

    // Operands are shifted right each RUN edge, so the active slice is always the low digit.
    assign w_sub      = {1'b0, r_a_sh[DIGIT_W-1:0]} - {1'b0, r_b_sh[DIGIT_W-1:0]}
                        - (DIGIT_W + 1)'(r_borrow);
    assign w_slice    = w_sub[DIGIT_W-1:0];
    assign w_slice_bo = w_sub[DIGIT_W];
    assign w_accept   = start && (r_state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_diff[int'(r_cnt) * DIGIT_W +: DIGIT_W] <= w_slice;
                    r_a_sh   <= r_a_sh >> DIGIT_W;
                    r_b_sh   <= r_b_sh >> DIGIT_W;
                    r_borrow <= w_slice_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_SLICE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bout  <= w_slice_bo;
                        // The top slice being written now carries the result sign bit.
                        r_ovf   <= (r_sign_a ^ r_sign_b) & (w_slice[DIGIT_W-1] ^ r_sign_a);
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_sub32.sv
// Self-checking bench for digit_serial_sub32: directed vector table, handshake
// corner sequences, and random operands checked against an arithmetic model.
module tb_digit_serial_sub32;

    localparam int WIDTH   = 32;
    localparam int DIGIT_W = 8;
    localparam int N       = WIDTH / DIGIT_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    digit_serial_sub32 #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_diff;
        logic        exp_bout;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] md, output logic mbo, output logic mov);
        longint sd;
        md  = ma - mb;
        mbo = (ma < mb);
        sd  = longint'($signed(ma)) - longint'($signed(mb));
        mov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endtask

    // Issue one operation from a negedge; returns outputs seen in the done cycle,
    // the number of negedges until done, and how many of those saw busy=1.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          output logic [31:0] rd, output logic rbo, output logic rov,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        rd  = diff;
        rbo = bout;
        rov = ovf;
    endtask

    vec_t        vecs[$];
    logic [31:0] rd, md;
    logic        rbo, rov, mbo, mov;
    int          lat, bcnt;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs.push_back('{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0});
        vecs.push_back('{32'hA0A0_E1FF, 32'hA0BF_FFE0, 32'hFFE0_E21F, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0});

        #12;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_diff", diff, 32'h0);
            check("idle_bout", 32'(bout), 32'd0);
            check("idle_ovf",  32'(ovf),  32'd0);
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, rd, rbo, rov, lat, bcnt);
            check("vec_latency", 32'(lat), 32'(N + 1));
            check("vec_busy_cycles", 32'(bcnt), 32'(N));
            check("vec_done", 32'(done), 32'd1);
            check("vec_diff", rd, vecs[i].exp_diff);
            check("vec_bout", 32'(rbo), 32'(vecs[i].exp_bout));
            check("vec_ovf",  32'(rov), 32'(vecs[i].exp_ovf));
            @(negedge clk);
            check("vec_done_pulse", 32'(done), 32'd0);
            check("vec_diff_hold", diff, vecs[i].exp_diff);
        end

        // start pulsed during RUN with different operands must be ignored
        @(negedge clk);
        start = 1'b1; a = 32'h0000_0005; b = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0; a = 32'h1111_1111;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'(N + 1));
        check("ignore_diff", diff, 32'h0000_0002);
        @(negedge clk);
        check("ignore_no_rerun", 32'(busy), 32'd0);

        // back-to-back: start held in the DONE cycle
        run_op(32'h0000_0020, 32'h0000_0001, rd, rbo, rov, lat, bcnt);
        check("b2b_first_diff", rd, 32'h0000_001F);
        start = 1'b1; a = 32'h0000_0010; b = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_gap", 32'(lat), 32'(N + 1));
        check("b2b_diff", diff, 32'h0000_000F);
        check("b2b_bout", 32'(bout), 32'd0);

        // asynchronous reset after two RUN edges
        @(negedge clk);
        start = 1'b1; a = 32'h0000_0100; b = 32'h0000_0200;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", diff, 32'h0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'({busy, done}), 32'd0);
        end
        run_op(32'h0000_0009, 32'h0000_0009, rd, rbo, rov, lat, bcnt);
        check("post_rst_latency", 32'(lat), 32'(N + 1));
        check("post_rst_diff", rd, 32'h0);
        check("post_rst_bout", 32'(rbo), 32'd0);
        check("post_rst_ovf",  32'(rov), 32'd0);

        // random operands against the arithmetic model; mix in sign-boundary values
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = {ra[31], 31'h0} | 32'(ra[3:0]);
            if (i % 4 == 2) rb = {~ra[31], rb[30:0]};
            model(ra, rb, md, mbo, mov);
            run_op(ra, rb, rd, rbo, rov, lat, bcnt);
            check("rnd_latency", 32'(lat), 32'(N + 1));
            check("rnd_diff", rd, md);
            check("rnd_bout", 32'(rbo), 32'(mbo));
            check("rnd_ovf",  32'(rov), 32'(mov));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
